// File: rtl/niosii_demo_switch_poller.sv
// Avalon-MM sequencer: programs the switches PIO irq mask, polls and debounces
// the switch value, and mirrors each accepted value onto the LED PIO.
module niosii_demo_switch_poller #(
  parameter int          POLL_DIV      = 50000,
  parameter int          DEBOUNCE      = 3,
  parameter logic [9:0]  IRQ_MASK_INIT = 10'h3FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [1:0]  sw_address,
  output logic        sw_chipselect,
  output logic        sw_write_n,
  output logic [31:0] sw_writedata,
  input  logic [31:0] sw_readdata,
  input  logic        sw_irq,
  output logic [1:0]  led_address,
  output logic        led_chipselect,
  output logic        led_write_n,
  output logic [31:0] led_writedata,
  output logic [9:0]  sw_value,
  output logic        sw_changed,
  output logic        busy
);

  localparam int             CW     = $clog2(POLL_DIV);
  localparam logic [CW-1:0]  RELOAD = CW'(POLL_DIV - 1);
  localparam logic [3:0]     DEB    = 4'(DEBOUNCE);

  typedef enum logic [2:0] {INIT_MASK, WAIT, RD_REQ, RD_CAP, LED_WR} state_t;

  typedef struct packed {
    logic        cs;
    logic        wr_n;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } bus_t;

  localparam bus_t BUS_IDLE = '{cs: 1'b0, wr_n: 1'b1, addr: 2'd0, wdata: 32'd0};

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          irq_q;
  logic [9:0]    cand_q, cand_d;
  logic [3:0]    match_q, match_d;
  logic [9:0]    value_q, value_d;
  logic          changed_q, changed_d;
  logic          busy_q, busy_d;
  bus_t          sw_bus_q, sw_bus_d;
  bus_t          led_bus_q, led_bus_d;

  logic [9:0]    sample;
  logic          irq_edge;
  logic          unused_rd_hi;

  assign sample       = sw_readdata[9:0];
  assign irq_edge     = sw_irq & ~irq_q;
  assign unused_rd_hi = ^sw_readdata[31:10];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    match_d   = match_q;
    value_d   = value_q;
    sw_bus_d  = BUS_IDLE;
    led_bus_d = BUS_IDLE;

    case (state_q)
      INIT_MASK: state_d = WAIT;
      WAIT: begin
        if (enable) begin
          if (cnt_q == '0 || irq_edge) begin
            state_d = RD_REQ;
            cnt_d   = RELOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      RD_REQ: state_d = RD_CAP;
      RD_CAP: begin
        if (sample == cand_q) begin
          match_d = (match_q == DEB) ? DEB : match_q + 4'd1;
        end else begin
          cand_d  = sample;
          match_d = 4'd1;
        end
        state_d = (match_d == DEB && cand_d != value_q) ? LED_WR : WAIT;
      end
      LED_WR:  state_d = WAIT;
      default: state_d = INIT_MASK;
    endcase

    // Outputs are registered from the upcoming state so each bus cycle lines
    // up with its state; the mask write is the one issued on leaving reset.
    if (state_q == INIT_MASK)
      sw_bus_d = '{cs: 1'b1, wr_n: 1'b0, addr: 2'd2, wdata: {22'b0, IRQ_MASK_INIT}};
    else if (state_d == RD_REQ)
      sw_bus_d = '{cs: 1'b1, wr_n: 1'b1, addr: 2'd0, wdata: 32'd0};

    if (state_d == LED_WR) begin
      led_bus_d = '{cs: 1'b1, wr_n: 1'b0, addr: 2'd0, wdata: {22'b0, cand_d}};
      value_d   = cand_d;
    end

    changed_d = (state_d == LED_WR);
    busy_d    = (state_d != WAIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= INIT_MASK;
      cnt_q     <= RELOAD;
      irq_q     <= 1'b0;
      cand_q    <= '0;
      match_q   <= '0;
      value_q   <= '0;
      changed_q <= 1'b0;
      busy_q    <= 1'b0;
      sw_bus_q  <= BUS_IDLE;
      led_bus_q <= BUS_IDLE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      irq_q     <= sw_irq;
      cand_q    <= cand_d;
      match_q   <= match_d;
      value_q   <= value_d;
      changed_q <= changed_d;
      busy_q    <= busy_d;
      sw_bus_q  <= sw_bus_d;
      led_bus_q <= led_bus_d;
    end
  end

  assign sw_address     = sw_bus_q.addr;
  assign sw_chipselect  = sw_bus_q.cs;
  assign sw_write_n     = sw_bus_q.wr_n;
  assign sw_writedata   = sw_bus_q.wdata;
  assign led_address    = led_bus_q.addr;
  assign led_chipselect = led_bus_q.cs;
  assign led_write_n    = led_bus_q.wr_n;
  assign led_writedata  = led_bus_q.wdata;
  assign sw_value       = value_q;
  assign sw_changed     = changed_q;
  assign busy           = busy_q;

endmodule

// File: doc/niosii_demo_switch_poller.md
# niosII_demo_switch_poller

Hardware sequencer for the switches PIO. It acts as an Avalon-MM master on the PIO's s1 slave, so no Nios II software has to poll. After reset it programs the PIO interrupt mask, then reads the switch data register at a fixed interval or early on a new interrupt, and debounces the samples. Each accepted new switch value is written to the LED PIO and announced with a one-cycle pulse.

## Interface
Parameters:
- POLL_DIV, 50000: cycles spent in WAIT between polls; ≥ 2.
- DEBOUNCE, 3: consecutive identical samples required before a value is accepted; range 1..15.
- IRQ_MASK_INIT, 10'h3FF: value written to the switches PIO irq_mask (address 2) after reset.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = polling allowed; 0 = hold in WAIT.
- sw_address  out  2  switches PIO address.
- sw_chipselect  out  1  switches PIO chipselect.
- sw_write_n  out  1  switches PIO write strobe, active low.
- sw_writedata  out  32  switches PIO write data.
- sw_readdata  in  32  switches PIO read data; registered, valid the cycle after a read.
- sw_irq  in  1  switches PIO irq (level).
- led_address  out  2  LED PIO address.
- led_chipselect  out  1  LED PIO chipselect.
- led_write_n  out  1  LED PIO write strobe, active low.
- led_writedata  out  32  LED PIO write data.
- sw_value  out  10  last accepted (debounced) switch value.
- sw_changed  out  1  one-cycle pulse when sw_value updates.
- busy  out  1  1 in any state other than WAIT.

## Operation
- FSM states: INIT_MASK, WAIT, RD_REQ, RD_CAP, LED_WR. All bus outputs are registered Moore outputs, with no input-to-output combinational path.
- Reset values:
  - sw_/led_ chipselect = 0, write_n = 1, address = 0, writedata = 0.
  - sw_value = 0, sw_changed = 0, busy = 0.
  - candidate = 0, match count = 0.
  - Poll counter = POLL_DIV-1; irq edge register = 0; state = INIT_MASK.
- INIT_MASK, one cycle:
  - Drives sw_chipselect=1, sw_write_n=0, sw_address=2, sw_writedata={22'b0, IRQ_MASK_INIT}.
  - Goes to WAIT. This state is entered only from reset.
- WAIT:
  - Bus idle. The counter decrements each cycle while enable=1.
  - Goes to RD_REQ when the counter reaches 0.
  - Also goes to RD_REQ early on an sw_irq rising edge (sw_irq=1 and registered previous value 0) while enable=1.
  - The counter reloads to POLL_DIV-1 on every exit.
  - enable=0: counter frozen and irq edges ignored; the irq edge register still tracks sw_irq.
- RD_REQ, one cycle: sw_chipselect=1, sw_write_n=1, sw_address=0. Goes to RD_CAP.
- RD_CAP, one cycle; sample = sw_readdata[9:0]:
  - If sample == candidate, the match count increments, saturating at DEBOUNCE.
  - Otherwise candidate = sample and count = 1.
  - If the updated count == DEBOUNCE and candidate != sw_value, go to LED_WR. Otherwise go to WAIT.
- LED_WR, one cycle:
  - Drives led_chipselect=1, led_write_n=0, led_address=0, led_writedata={22'b0, candidate}.
  - sw_value <= candidate and sw_changed=1 on this cycle only.
  - Goes to WAIT.
- Any state started (RD_REQ, RD_CAP, LED_WR) always completes; enable is sampled only in WAIT.
- Reset asserted in any state: all registers return to reset values on the next edge; a partial bus cycle is abandoned.

## Timing
- First bus write (mask) appears on the first edge after reset deasserts.
- Poll period with no change = POLL_DIV + 2 cycles. With an LED update it is POLL_DIV + 3 cycles.
- Read latency: the address is presented in RD_REQ and data is captured in RD_CAP, one cycle later.
- Stable switch change to LED write: at most DEBOUNCE poll periods + 1 cycle.
- sw_irq held high does not cause repeated early polls; only rising edges count.
- An irq edge that arrives while the FSM is not in WAIT is lost; the next timed poll covers it.

## Test plan
All scenarios use POLL_DIV=4, DEBOUNCE=3, IRQ_MASK_INIT=10'h155.
- Reset release: the cycle after deassert shows sw_address=2, sw_write_n=0, sw_writedata=32'h155. Then 4 WAIT cycles, then a read at address 0 with busy=1.
- Switches set to 10'h2A5 and held: after the 3rd capture, LED_WR writes 32'h2A5, sw_value=10'h2A5, and sw_changed pulses once. Later polls produce no LED write.
- Bounce: samples 10'h001, 10'h000, 10'h001, 10'h001, 10'h001. The first 10'h001 run is broken by 10'h000, so no LED write occurs until the third consecutive 10'h001.
- sw_irq rising at WAIT counter=3: RD_REQ occurs on the next cycle. sw_irq then held high: the following poll waits the full 4 cycles.
- enable=0 for 20 cycles in WAIT: no chipselect on either port. After enable=1, a poll occurs after 4 cycles.
- Reset asserted during LED_WR: the next cycle shows led_chipselect=0, sw_value=0, and state INIT_MASK with a mask write following.
